// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared sizes, FSM encoding and address-range check for the
//               dual-issue memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr);
    return addr < DATA_W'(MEM_DEPTH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dual_mem_stage_data_mem.sv
// ============================================================================
// Module      : data_mem
// Description : Synchronous data RAM; single port by default, two ports when
//               DUAL_MEM_STAGE_TWO_PORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic [DATA_W-1:0] rdata0_o
`ifdef DUAL_MEM_STAGE_TWO_PORT_EN
  ,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [DATA_W-1:0] rdata1_o
`endif
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata0_q;

`ifdef DUAL_MEM_STAGE_TWO_PORT_EN
  logic [DATA_W-1:0] rdata1_q;

  // Port 1 write is issued last so it wins a same-address collision;
  // port 1 reads see port 0's same-cycle store through the bypass.
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[addr0_i] <= wdata0_i;
    if (we1_i) mem_q[addr1_i] <= wdata1_i;
    rdata0_q <= mem_q[addr0_i];
    rdata1_q <= (we0_i && (addr0_i == addr1_i)) ? wdata0_i : mem_q[addr1_i];
  end

  assign rdata1_o = rdata1_q;
`else
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[addr0_i] <= wdata0_i;
    rdata0_q <= mem_q[addr0_i];
  end
`endif

  assign rdata0_o = rdata0_q;

endmodule

`default_nettype wire

// File: rtl/dual_mem_stage.sv
// ============================================================================
// Module      : dual_mem_stage
// Description : Dual-lane memory-access stage; serializes same-cycle memory
//               ops lane 0 first unless DUAL_MEM_STAGE_TWO_PORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex0_valid,
  input  logic              ex1_valid,
  input  logic [DATA_W-1:0] ex0_result,
  input  logic [DATA_W-1:0] ex1_result,
  input  logic [DATA_W-1:0] ex0_store_data,
  input  logic [DATA_W-1:0] ex1_store_data,
  input  logic              ex0_mem_read,
  input  logic              ex1_mem_read,
  input  logic              ex0_mem_write,
  input  logic              ex1_mem_write,
  input  logic              ex0_oob,
  input  logic              ex1_oob,
  input  logic [4:0]        ex0_rd,
  input  logic [4:0]        ex1_rd,
  input  logic              ex0_reg_write,
  input  logic              ex1_reg_write,
  output logic              stall,
  output logic              wb0_valid,
  output logic              wb1_valid,
  output logic [DATA_W-1:0] wb0_data,
  output logic [DATA_W-1:0] wb1_data,
  output logic [4:0]        wb0_rd,
  output logic [4:0]        wb1_rd,
  output logic              wb0_reg_write,
  output logic              wb1_reg_write,
  output logic              mem_fault,
  output logic              fault_lane,
  output logic [DATA_W-1:0] fault_addr
);

  logic w_mop0, w_mop1, w_flt0, w_flt1;
  logic w_take0, w_take1, w_acc0, w_acc1;
  logic [DATA_W-1:0] w_rdata0, w_rdata1;

  assign w_mop0 = ex0_valid & (ex0_mem_read | ex0_mem_write);
  assign w_mop1 = ex1_valid & (ex1_mem_read | ex1_mem_write);
  assign w_flt0 = w_mop0 & (ex0_oob | ~addr_in_range(ex0_result));
  assign w_flt1 = w_mop1 & (ex1_oob | ~addr_in_range(ex1_result));
  assign w_acc0 = w_take0 & w_mop0 & ~w_flt0;
  assign w_acc1 = w_take1 & w_mop1 & ~w_flt1;

`ifdef DUAL_MEM_STAGE_TWO_PORT_EN
  assign w_take0 = ex0_valid;
  assign w_take1 = ex1_valid & ~w_flt0;
  assign stall   = 1'b0;

  data_mem u_mem (
    .clk      (clk),
    .we0_i    (rst & w_acc0 & ex0_mem_write),
    .addr0_i  (ex0_result[ADDR_W-1:0]),
    .wdata0_i (ex0_store_data),
    .rdata0_o (w_rdata0),
    .we1_i    (rst & w_acc1 & ex1_mem_write),
    .addr1_i  (ex1_result[ADDR_W-1:0]),
    .wdata1_i (ex1_store_data),
    .rdata1_o (w_rdata1)
  );
`else
  state_e state_q;
  logic   w_conflict, w_second;

  assign w_conflict = w_mop0 & w_mop1 & ~w_flt0;
  assign w_second   = (state_q == SECOND);
  assign w_take0    = ~w_second & ex0_valid;
  assign w_take1    = w_second ? ex1_valid : (ex1_valid & ~w_flt0 & ~w_conflict);
  assign stall      = ~w_second & w_conflict;

  // At most one lane accesses the single port in any cycle.
  data_mem u_mem (
    .clk      (clk),
    .we0_i    (rst & (w_acc0 ? ex0_mem_write : (w_acc1 & ex1_mem_write))),
    .addr0_i  (w_acc0 ? ex0_result[ADDR_W-1:0] : ex1_result[ADDR_W-1:0]),
    .wdata0_i (w_acc0 ? ex0_store_data : ex1_store_data),
    .rdata0_o (w_rdata0)
  );

  assign w_rdata1 = w_rdata0;
`endif

  logic              wb0_valid_d, wb1_valid_d, wb0_rw_d, wb1_rw_d;
  logic              wb0_load_d, wb1_load_d, fault_d, fault_lane_d;
  logic [4:0]        wb0_rd_d, wb1_rd_d;
  logic [DATA_W-1:0] wb0_data_d, wb1_data_d, fault_addr_d;

  logic              wb0_valid_q, wb1_valid_q, wb0_rw_q, wb1_rw_q;
  logic              wb0_load_q, wb1_load_q, fault_q, fault_lane_q;
  logic [4:0]        wb0_rd_q, wb1_rd_q;
  logic [DATA_W-1:0] wb0_data_q, wb1_data_q, fault_addr_q;

  always_comb begin
    wb0_valid_d  = w_take0;
    wb0_rd_d     = w_take0 ? ex0_rd : 5'd0;
    wb0_rw_d     = w_take0 & ex0_reg_write & ~w_flt0 & ~ex0_mem_write;
    wb0_data_d   = (w_take0 & ~w_flt0) ? ex0_result : '0;
    wb0_load_d   = w_acc0 & ex0_mem_read;
    wb1_valid_d  = w_take1;
    wb1_rd_d     = w_take1 ? ex1_rd : 5'd0;
    wb1_rw_d     = w_take1 & ex1_reg_write & ~w_flt1 & ~ex1_mem_write;
    wb1_data_d   = (w_take1 & ~w_flt1) ? ex1_result : '0;
    wb1_load_d   = w_acc1 & ex1_mem_read;
    // Lane 0 fault squashes lane 1, so at most one lane faults per cycle.
    fault_d      = (w_take0 & w_flt0) | (w_take1 & w_flt1);
    fault_lane_d = ~(w_take0 & w_flt0) & (w_take1 & w_flt1);
    fault_addr_d = (w_take0 & w_flt0) ? ex0_result :
                   ((w_take1 & w_flt1) ? ex1_result : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifndef DUAL_MEM_STAGE_TWO_PORT_EN
      state_q      <= IDLE;
`endif
      wb0_valid_q  <= 1'b0;
      wb1_valid_q  <= 1'b0;
      wb0_rw_q     <= 1'b0;
      wb1_rw_q     <= 1'b0;
      wb0_load_q   <= 1'b0;
      wb1_load_q   <= 1'b0;
      wb0_rd_q     <= 5'd0;
      wb1_rd_q     <= 5'd0;
      wb0_data_q   <= '0;
      wb1_data_q   <= '0;
      fault_q      <= 1'b0;
      fault_lane_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
`ifndef DUAL_MEM_STAGE_TWO_PORT_EN
      state_q      <= stall ? SECOND : IDLE;
`endif
      wb0_valid_q  <= wb0_valid_d;
      wb1_valid_q  <= wb1_valid_d;
      wb0_rw_q     <= wb0_rw_d;
      wb1_rw_q     <= wb1_rw_d;
      wb0_load_q   <= wb0_load_d;
      wb1_load_q   <= wb1_load_d;
      wb0_rd_q     <= wb0_rd_d;
      wb1_rd_q     <= wb1_rd_d;
      wb0_data_q   <= wb0_data_d;
      wb1_data_q   <= wb1_data_d;
      fault_q      <= fault_d;
      fault_lane_q <= fault_lane_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign wb0_valid     = wb0_valid_q;
  assign wb1_valid     = wb1_valid_q;
  assign wb0_reg_write = wb0_rw_q;
  assign wb1_reg_write = wb1_rw_q;
  assign wb0_rd        = wb0_rd_q;
  assign wb1_rd        = wb1_rd_q;
  assign wb0_data      = wb0_load_q ? w_rdata0 : wb0_data_q;
  assign wb1_data      = wb1_load_q ? w_rdata1 : wb1_data_q;
  assign mem_fault     = fault_q;
  assign fault_lane    = fault_lane_q;
  assign fault_addr    = fault_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_mem_stage.sv
// ============================================================================
// Module      : tb_dual_mem_stage
// Description : Directed self-checking bench for dual_mem_stage; covers the
//               DUAL_MEM_STAGE_TWO_PORT_EN build when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex0_valid, ex1_valid;
  logic [31:0] ex0_result, ex1_result, ex0_store_data, ex1_store_data;
  logic        ex0_mem_read, ex1_mem_read, ex0_mem_write, ex1_mem_write;
  logic        ex0_oob, ex1_oob;
  logic [4:0]  ex0_rd, ex1_rd;
  logic        ex0_reg_write, ex1_reg_write;
  logic        stall, wb0_valid, wb1_valid;
  logic [31:0] wb0_data, wb1_data;
  logic [4:0]  wb0_rd, wb1_rd;
  logic        wb0_reg_write, wb1_reg_write;
  logic        mem_fault, fault_lane;
  logic [31:0] fault_addr;

  int checks   = 0;
  int failures = 0;

  dual_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex0_valid(ex0_valid), .ex1_valid(ex1_valid),
    .ex0_result(ex0_result), .ex1_result(ex1_result),
    .ex0_store_data(ex0_store_data), .ex1_store_data(ex1_store_data),
    .ex0_mem_read(ex0_mem_read), .ex1_mem_read(ex1_mem_read),
    .ex0_mem_write(ex0_mem_write), .ex1_mem_write(ex1_mem_write),
    .ex0_oob(ex0_oob), .ex1_oob(ex1_oob),
    .ex0_rd(ex0_rd), .ex1_rd(ex1_rd),
    .ex0_reg_write(ex0_reg_write), .ex1_reg_write(ex1_reg_write),
    .stall(stall),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid),
    .wb0_data(wb0_data), .wb1_data(wb1_data),
    .wb0_rd(wb0_rd), .wb1_rd(wb1_rd),
    .wb0_reg_write(wb0_reg_write), .wb1_reg_write(wb1_reg_write),
    .mem_fault(mem_fault), .fault_lane(fault_lane), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // v, result, store data, mem_read, mem_write, oob, rd, reg_write
  task automatic lane0(input logic v, input logic [31:0] res, input logic [31:0] sd,
                       input logic mr, input logic mw, input logic oob,
                       input logic [4:0] rd, input logic rw);
    ex0_valid = v; ex0_result = res; ex0_store_data = sd; ex0_mem_read = mr;
    ex0_mem_write = mw; ex0_oob = oob; ex0_rd = rd; ex0_reg_write = rw;
  endtask

  task automatic lane1(input logic v, input logic [31:0] res, input logic [31:0] sd,
                       input logic mr, input logic mw, input logic oob,
                       input logic [4:0] rd, input logic rw);
    ex1_valid = v; ex1_result = res; ex1_store_data = sd; ex1_mem_read = mr;
    ex1_mem_write = mw; ex1_oob = oob; ex1_rd = rd; ex1_reg_write = rw;
  endtask

  task automatic idle();
    lane0(0, 0, 0, 0, 0, 0, 0, 0);
    lane1(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle();
    step(); step();
    chk("rst_wb0_valid", 32'(wb0_valid), 0);
    chk("rst_wb1_valid", 32'(wb1_valid), 0);
    chk("rst_wb0_data", wb0_data, 0);
    chk("rst_wb1_rw", 32'(wb1_reg_write), 0);
    chk("rst_fault", 32'(mem_fault), 0);
    chk("rst_fault_addr", fault_addr, 0);
    rst = 1'b1;

    // Lane 0 store, lane 1 ALU pass-through
    lane0(1, 10, 32'hDEADBEEF, 0, 1, 0, 1, 0);
    lane1(1, 7, 0, 0, 0, 0, 3, 1);
    #1 chk("st_nop_stall", 32'(stall), 0);
    step();
    chk("st_nop_wb1_data", wb1_data, 7);
    chk("st_nop_wb1_rw", 32'(wb1_reg_write), 1);
    chk("st_nop_wb1_rd", 32'(wb1_rd), 3);
    chk("st_nop_wb0_rw", 32'(wb0_reg_write), 0);

    lane0(1, 10, 0, 1, 0, 0, 4, 1);
    lane1(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("ld10_wb0_data", wb0_data, 32'hDEADBEEF);
    chk("ld10_wb0_rw", 32'(wb0_reg_write), 1);
    chk("ld10_wb1_valid", 32'(wb1_valid), 0);

`ifdef DUAL_MEM_STAGE_TWO_PORT_EN
    // Same-address stores: lane 1 wins
    lane0(1, 5, 32'h1, 0, 1, 0, 0, 0);
    lane1(1, 5, 32'h2, 0, 1, 0, 0, 0);
    #1 chk("tp_stall", 32'(stall), 0);
    step();
    chk("tp_wb1_valid", 32'(wb1_valid), 1);
    lane0(1, 5, 0, 1, 0, 0, 2, 1);
    lane1(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("tp_ld5", wb0_data, 32'h2);

    // Lane 1 load bypasses lane 0 same-cycle store
    lane0(1, 6, 32'h33, 0, 1, 0, 0, 0);
    lane1(1, 6, 0, 1, 0, 0, 9, 1);
    #1 chk("tp_byp_stall", 32'(stall), 0);
    step();
    chk("tp_byp_wb1", wb1_data, 32'h33);
    chk("tp_byp_wb0_valid", 32'(wb0_valid), 1);
`else
    // Conflict: store then load same address, serialized
    lane0(1, 20, 32'h55, 0, 1, 0, 0, 0);
    lane1(1, 20, 0, 1, 0, 0, 5, 1);
    #1 chk("cf_stall", 32'(stall), 1);
    step();
    chk("cf_n1_wb0_valid", 32'(wb0_valid), 1);
    chk("cf_n1_wb1_valid", 32'(wb1_valid), 0);
    chk("cf_second_stall", 32'(stall), 0);
    step();
    chk("cf_n2_wb0_valid", 32'(wb0_valid), 0);
    chk("cf_n2_wb1_valid", 32'(wb1_valid), 1);
    chk("cf_n2_wb1_data", wb1_data, 32'h55);
    chk("cf_n2_wb1_rw", 32'(wb1_reg_write), 1);
`endif

    // Lane 0 out-of-bound load squashes lane 1 store
    lane0(1, 300, 0, 1, 0, 1, 6, 1);
    lane1(1, 10, 32'h12345678, 0, 1, 0, 0, 0);
    #1 chk("f0_stall", 32'(stall), 0);
    step();
    chk("f0_fault", 32'(mem_fault), 1);
    chk("f0_lane", 32'(fault_lane), 0);
    chk("f0_addr", fault_addr, 300);
    chk("f0_wb0_valid", 32'(wb0_valid), 1);
    chk("f0_wb0_rw", 32'(wb0_reg_write), 0);
    chk("f0_wb0_data", wb0_data, 0);
    chk("f0_wb1_valid", 32'(wb1_valid), 0);
    lane0(1, 10, 0, 1, 0, 0, 4, 1);
    lane1(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("f0_mem_kept", wb0_data, 32'hDEADBEEF);
    chk("f0_pulse_end", 32'(mem_fault), 0);

    // Seed addr 0, then lane 1 store to 256 (wraps to 0 if unchecked)
    lane0(1, 0, 32'h11111111, 0, 1, 0, 0, 0);
    step();
    lane0(1, 32'h99, 0, 0, 0, 0, 7, 1);
    lane1(1, 256, 32'hAAAA, 0, 1, 0, 0, 1);
    step();
    chk("f1_fault", 32'(mem_fault), 1);
    chk("f1_lane", 32'(fault_lane), 1);
    chk("f1_addr", fault_addr, 256);
    chk("f1_wb0_data", wb0_data, 32'h99);
    chk("f1_wb0_rw", 32'(wb0_reg_write), 1);
    chk("f1_wb1_valid", 32'(wb1_valid), 1);
    chk("f1_wb1_rw", 32'(wb1_reg_write), 0);
    lane0(1, 0, 0, 1, 0, 0, 4, 1);
    lane1(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("f1_mem_kept", wb0_data, 32'h11111111);

`ifndef DUAL_MEM_STAGE_TWO_PORT_EN
    // Reset while SECOND abandons lane 1 store
    lane0(1, 40, 32'h77, 0, 1, 0, 0, 0);
    lane1(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    lane0(1, 10, 0, 1, 0, 0, 8, 1);
    lane1(1, 40, 32'h99, 0, 1, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    chk("rs_wb0_valid", 32'(wb0_valid), 0);
    chk("rs_wb1_valid", 32'(wb1_valid), 0);
    chk("rs_wb1_data", wb1_data, 0);
    chk("rs_fault", 32'(mem_fault), 0);
    rst = 1'b1;
    lane0(1, 40, 0, 1, 0, 0, 9, 1);
    lane1(1, 40, 0, 1, 0, 0, 10, 1);
    #1 chk("rs_idle_stall", 32'(stall), 1);
    step();
    chk("rs_ld40_wb0", wb0_data, 32'h77);
    step();
    chk("rs_ld40_wb1", wb1_data, 32'h77);
    chk("rs_ld40_rd", 32'(wb1_rd), 10);
`endif

    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dual_mem_stage.md
# dual_mem_stage

Memory-access stage of the dual-issue pipeline, directly downstream of the two EX-stage ALUs. Takes each lane's ALU result as data address or pass-through value, performs loads and stores against a 256-word data memory, and presents per-lane writeback results one cycle later. Memory operations from both lanes in the same cycle are serialized, lane 0 first, by stalling upstream for one cycle. Out-of-bound accesses are suppressed and reported as a fault.

## Interface
- MEM_DEPTH, 256: data memory words; valid addresses 0..MEM_DEPTH-1.
- DATA_W, 32: datapath width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low.
- ex0_valid, ex1_valid  input  1  lane instruction present.
- ex0_result, ex1_result  input  DATA_W  ALU result (address for memory ops).
- ex0_store_data, ex1_store_data  input  DATA_W  store value.
- ex0_mem_read, ex1_mem_read / ex0_mem_write, ex1_mem_write  input  1  load / store.
- ex0_oob, ex1_oob  input  1  ALU memory_out_of_bound flag.
- ex0_rd, ex1_rd  input  5  destination register.
- ex0_reg_write, ex1_reg_write  input  1  writes register file.
- stall  output  1  combinational; upstream holds EX outputs while high.
- wb0_valid, wb1_valid  output  1  writeback slot valid.
- wb0_data, wb1_data  output  DATA_W  load data or forwarded ALU result.
- wb0_rd, wb1_rd  output  5;  wb0_reg_write, wb1_reg_write  output  1.
- mem_fault  output  1  one-cycle pulse on a suppressed access.
- fault_lane  output  1;  fault_addr  output  DATA_W.

## Operation
- Memory op = valid & (mem_read | mem_write). Fault = memory op & (ex_oob | result >= MEM_DEPTH).
- Faulting access: no write; wb reg_write forced 0; wb_valid 1; wb_data 0; mem_fault, fault_lane, fault_addr registered with the writeback.
- Lane 0 fault squashes lane 1 of the same pair (wb1_valid 0, no access, no stall). Lane 1 fault leaves lane 0 unaffected.
- Non-memory op: wb_data = result. Load: wb_data = mem[result]. Store: wb_reg_write 0.
- Both valid with both mem_read/mem_write flag sets active and no lane 0 fault = conflict.
- FSM, state IDLE or SECOND:
  - IDLE, no conflict: both lanes processed this cycle; stall 0.
  - IDLE, conflict: lane 0 accesses memory; lane 1 held; stall 1; go to SECOND.
  - SECOND: held lane 0 inputs ignored; lane 1 accesses memory; stall 0; return to IDLE.
- Ordering: lane 0 retires before lane 1, so same-rd writes and store→load pairs resolve in program order.

## Timing
- Latency: inputs sampled at edge N; wb outputs valid from N+1 to N+2. Memory read is synchronous and aligned with the output register.
- Conflict: wb0 valid at N+1 with wb1_valid 0; wb1 valid at N+2 with wb0_valid 0.
- Reset values: all wb_* 0, mem_fault 0, fault_lane 0, fault_addr 0, FSM IDLE. Memory contents are not reset.
- Reset asserted in SECOND: the pending lane 1 access is abandoned, with no write and no writeback.
- stall depends only on the FSM state and current inputs. It never depends on wb outputs.

## Configuration
- DUAL_MEM_STAGE_TWO_PORT_EN defined:
  - The data memory has two write/read ports, so there is no FSM, and stall is tied to 0.
  - Same-address store/store in one cycle: lane 1 value wins.
  - Lane 1 load of the address lane 0 stores in the same cycle returns lane 0 store data through a bypass.
- Undefined: single-port memory with the serialization FSM above.

## Structure
- Package mem_stage_pkg: MEM_DEPTH, DATA_W, the FSM state encoding (IDLE=0, SECOND=1), and the address-range check function.
- Sub-module data_mem: synchronous RAM, one port by default, two ports under DUAL_MEM_STAGE_TWO_PORT_EN. It contains only storage and no fault logic.

## Test plan
- Lane 0 store 0xDEADBEEF at addr 10, lane 1 nop with result 7, rd 3 → next cycle: wb1_data=7, wb1_reg_write=1, stall never high. A later lane 0 load of addr 10 → wb0_data=0xDEADBEEF.
- Lane 0 store 0x55 at addr 20, lane 1 load addr 20 in the same cycle → stall=1 for one cycle. wb0 valid at N+1, then wb1_data=0x55 at N+2.
- Lane 0 load addr 300 (ex0_oob=1) paired with a lane 1 store → mem_fault=1, fault_lane=0, fault_addr=300. wb0_reg_write=0, wb1_valid=0, memory unchanged, no stall.
- Lane 1 store at addr 256 with ex1_oob=0 → range check faults: fault_lane=1, no write. Lane 0 ALU result retires normally.
- Conflict pair, with rst driven low during SECOND → next cycle all outputs 0, FSM IDLE, lane 1 store address unchanged.
- With DUAL_MEM_STAGE_TWO_PORT_EN: both lanes store to addr 5 (0x1, 0x2) → stall 0, and a later load returns 0x2.
